// File: rtl/rr_mux_2x1.sv
// -----------------------------------------------------------------------------
// rr_mux_2x1
//
// Two-channel round-robin stream merger. Arbitrates between two valid/ready
// producers, registers the granted word into a single output stage and drives
// the 2x1 mux select S for the word currently held in that stage.
//
// Parameters:
//   DW         data width of both inputs and the output
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in0_data   channel 0 word
//   in0_valid  channel 0 offers a word
//   in0_ready  channel 0 word is taken this cycle
//   in1_data   channel 1 word
//   in1_valid  channel 1 offers a word
//   in1_ready  channel 1 word is taken this cycle
//   out_data   registered merged word
//   out_valid  out_data holds a word
//   out_ready  consumer takes the word this cycle
//   S          select (0 = in0, 1 = in1) of the word in out_data
// -----------------------------------------------------------------------------
module rr_mux_2x1 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in0_data,
   input  logic          in0_valid,
   output logic          in0_ready,
   input  logic [DW-1:0] in1_data,
   input  logic          in1_valid,
   output logic          in1_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          S
);

   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          s_q, s_d;
   logic          last_q, last_d;

   logic          free;
   logic          gnt_vld;
   logic          gnt_sel;

   // Arbitration: slot free test and round-robin grant
   always_comb begin
      free    = !out_valid_q || out_ready;
      gnt_vld = in0_valid || in1_valid;
      // On contention the channel not granted last time wins; otherwise the
      // only requester wins (in1_valid alone selects channel 1).
      if (in0_valid && in1_valid) begin
         gnt_sel = !last_q;
      end else begin
         gnt_sel = in1_valid;
      end
   end

   // A ready implies the matching valid: gnt_sel only points at a channel
   // that is requesting whenever gnt_vld is set. Reset suppresses both.
   always_comb begin
      in0_ready = !rst && free && gnt_vld && !gnt_sel;
      in1_ready = !rst && free && gnt_vld &&  gnt_sel;
   end

   // Next state of the output stage and the priority pointer
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      s_d         = s_q;
      last_d      = last_q;
      if (free) begin
         if (gnt_vld) begin
            out_data_d  = gnt_sel ? in1_data : in0_data;
            out_valid_d = 1'b1;
            s_d         = gnt_sel;
            last_d      = gnt_sel;
         end else begin
            // Slot drained with nothing to refill: data and select hold.
            out_valid_d = 1'b0;
         end
      end
   end

   // Output register stage; last resets to 1 so channel 0 wins first
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         s_q         <= 1'b0;
         last_q      <= 1'b1;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         last_q      <= last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign S         = s_q;

endmodule

// File: doc/rr_mux_2x1.md
# rr_mux_2x1

Two-channel round-robin stream merger that produces the select `S` for a 2x1 data mux and registers the selected word. It sits directly upstream of the 2x1 mux datapath: it arbitrates between two valid/ready producers, drives `S` from the grant, and presents one registered output stream to the consumer. Arbitration is fair, throughput is one word per cycle, and latency is one cycle.

## Interface
Parameters:
- `DW`, default 8: data width of each input and the output.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in0_data`, input, DW: channel 0 data.
- `in0_valid`, input, 1: channel 0 has a word.
- `in0_ready`, output, 1: channel 0 word is accepted this cycle.
- `in1_data`, input, DW: channel 1 data.
- `in1_valid`, input, 1: channel 1 has a word.
- `in1_ready`, output, 1: channel 1 word is accepted this cycle.
- `out_data`, output, DW: registered merged data.
- `out_valid`, output, 1: `out_data` holds a word.
- `out_ready`, input, 1: consumer accepts the word this cycle.
- `S`, output, 1: registered select (0 = in0, 1 = in1) of the word currently in `out_data`.

Reset is synchronous and active-high on `rst`, in the `clk` domain only.

## Operation
- **State**
  - Output register: `out_data`, `out_valid`, `S`.
  - Priority pointer `last`, 1 bit: the channel granted most recently.
- **Reset values**
  - `out_data` = 0, `out_valid` = 0, `S` = 0.
  - `last` = 1, so channel 0 wins the first contention.
- **Slot free**: `free = !out_valid || out_ready`. This is combinational.
- **Grant**, evaluated only when `free` = 1:
  - Only in0 valid: grant 0.
  - Only in1 valid: grant 1.
  - Both valid: grant `!last`.
  - Neither valid: no grant.
- **Ready outputs**
  - `inX_ready` = `free` && (grant == X).
  - At most one ready is high per cycle. Ready is never high for a channel whose valid is low.
- **On a grant** (rising edge): `out_data` ← granted data, `S` ← grant, `last` ← grant, `out_valid` ← 1.
- **Free with no grant**: `out_valid` ← 0. `out_data` and `S` hold their values.
- **Not free** (`out_valid` = 1, `out_ready` = 0): `out_data`, `S`, `out_valid` and `last` all hold.
- **Arbitration history**: `last` changes only on a grant. A single-valid grant also updates `last`.
- **Reset mid-transfer**: a word held in the output register is dropped. No ready is asserted in the reset cycle. `in0_ready` = `in1_ready` = 0 while `rst` = 1.
- **Handshake assumption**: producers hold `inX_data` stable while `inX_valid` = 1 and ready = 0. The block does not check this.

## Timing
- **Latency**: 1 cycle. A word accepted on edge N appears on `out_data` with `out_valid` = 1 after edge N.
- **Throughput**: one word per cycle while `out_ready` = 1.
  - With both inputs continuously valid, grants alternate 0,1,0,1, starting with 0 after reset.
- **Combinational paths**:
  - `inX_ready` depends on `out_ready`, `out_valid`, both `inX_valid` and `last`.
  - There is no path from data inputs to outputs.
- **Simultaneous drain and refill** (`out_valid` = 1, `out_ready` = 1, an input valid): the new word replaces the old in the same edge, with no bubble.
- **Back-pressure**: `out_ready` low for K cycles stalls both inputs for K cycles. No word is lost or duplicated.

## Test plan
- **Reset**: assert `rst` for 2 cycles with both inputs valid (`in0_data` = 8'hA0, `in1_data` = 8'hB0) → both readies 0, `out_valid` = 0, `out_data` = 0, `S` = 0. After release, first grant is in0: `out_data` = A0, `S` = 0.
- **Alternation**: both inputs continuously valid (in0 sends A0,A1,A2; in1 sends B0,B1,B2), `out_ready` = 1 → output sequence A0,B0,A1,B1,A2,B2 with `S` = 0,1,0,1,0,1. One word per cycle, no bubbles.
- **Single channel**: only in1 valid for 4 words (8'h10–8'h13), `out_ready` = 1 → 4 consecutive outputs 10..13, `S` = 1. Then both become valid → next grant goes to in0.
- **Back-pressure**: with `out_data` = 8'h55 valid, hold `out_ready` = 0 for 3 cycles while both inputs are valid → `out_data` stays 55, `S` holds, both readies 0. On `out_ready` = 1, the next word loads in that same edge.
- **Drain to empty**: one word 8'h7E from in0, then no valids, `out_ready` = 1 → `out_valid` high for exactly 1 cycle. After that, `out_valid` = 0 while `out_data` holds 7E and `S` holds 0.
- **Reset mid-stream**: assert `rst` while `out_valid` = 1, `out_ready` = 0 → next cycle `out_valid` = 0. After release, arbitration restarts with in0 first.
